// File: rtl/acpram_axi_arbiter.sv
// acpram_axi_arbiter: round-robin sharing of one ACPRAM<->AXI burst engine among NREQ requesters.
// Latency: command pulse 1 cycle after req_valid is sampled in IDLE; req_done 1 cycle after eng_done.
// Backpressure: no arbitration while eng_busy is high in IDLE; requesters hold req_valid until req_ready.
// Optional: `define ACPRAM_ARB_PRIO0_EN makes requester 0 high priority (it yields one slot after each win).
`timescale 1ns/1ps
module acpram_axi_arbiter #(
  parameter int NREQ      = 4,
  parameter int ACPRAM_AW = 10,
  parameter int AXI_AW    = 32,
  localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clock_i,
  input  logic                      resetn_i,
  input  logic [NREQ-1:0]           req_valid_i,
  input  logic [NREQ-1:0]           req_write_i,
  input  logic [NREQ-1:0]           req_len_i,
  input  logic [NREQ*ACPRAM_AW-1:0] req_acpram_addr_i,
  input  logic [NREQ*AXI_AW-1:0]    req_axi_addr_i,
  output logic [NREQ-1:0]           req_ready_o,
  output logic [NREQ-1:0]           req_done_o,
  output logic                      req_error_o,
  output logic                      eng_write_o,
  output logic                      eng_read_o,
  output logic                      eng_len_o,
  output logic [ACPRAM_AW-1:0]      eng_acpram_addr_o,
  output logic [AXI_AW-1:0]         eng_axi_addr_o,
  input  logic                      eng_busy_i,
  input  logic                      eng_done_i,
  input  logic                      eng_error_i,
  output logic [GW-1:0]             grant_id_o,
  output logic                      active_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic                 wr_q, wr_d;
  logic                 len_q, len_d;
  logic [ACPRAM_AW-1:0] aa_q, aa_d;
  logic [AXI_AW-1:0]    xa_q, xa_d;
  logic                 err_q, err_d;
`ifdef ACPRAM_ARB_PRIO0_EN
  logic                 last0_q, last0_d;
`endif

  logic                 win_vld;
  logic [GW-1:0]        win_id;
  logic                 win_upd_rr;
  logic [NREQ-1:0]      cand;

  // Winner selection: first valid requester after rr_ptr, wrapping modulo NREQ.
  always_comb begin : pick
    int idx;
    idx        = 0;
    win_vld    = 1'b0;
    win_id     = '0;
    win_upd_rr = 1'b1;
    cand       = req_valid_i;
`ifdef ACPRAM_ARB_PRIO0_EN
    // Requester 0 wins unless it won last time and someone else is waiting;
    // its wins leave rr_ptr alone so the others keep rotating among themselves.
    if (req_valid_i[0] && (!last0_q || (req_valid_i[NREQ-1:1] == '0))) begin
      win_vld    = 1'b1;
      win_id     = '0;
      win_upd_rr = 1'b0;
    end
    cand[0] = 1'b0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_id  = GW'(idx);
      end
    end
  end

  // Job FSM: next state, latched job fields and the one-hot pulse outputs.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    wr_d        = wr_q;
    len_d       = len_q;
    aa_d        = aa_q;
    xa_d        = xa_q;
    err_d       = err_q;
`ifdef ACPRAM_ARB_PRIO0_EN
    last0_d     = last0_q;
`endif
    req_ready_o = '0;
    req_done_o  = '0;
    req_error_o = 1'b0;
    eng_write_o = 1'b0;
    eng_read_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld && !eng_busy_i) begin
          state_d = S_ISSUE;
          grant_d = win_id;
          if (win_upd_rr) rr_ptr_d = win_id;
          wr_d    = req_write_i[win_id];
          len_d   = req_len_i[win_id];
          aa_d    = req_acpram_addr_i[win_id*ACPRAM_AW +: ACPRAM_AW];
          xa_d    = req_axi_addr_i[win_id*AXI_AW +: AXI_AW];
`ifdef ACPRAM_ARB_PRIO0_EN
          last0_d = (win_id == '0);
`endif
        end
      end
      S_ISSUE: begin
        eng_write_o          = wr_q;
        eng_read_o           = !wr_q;
        req_ready_o[grant_q] = 1'b1;
        state_d              = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done_i) begin
          err_d   = eng_error_i;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        req_done_o[grant_q] = 1'b1;
        req_error_o         = err_q;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and job registers; reset drops any job in flight without a done.
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= GW'(NREQ-1);
      grant_q  <= '0;
      wr_q     <= 1'b0;
      len_q    <= 1'b0;
      aa_q     <= '0;
      xa_q     <= '0;
      err_q    <= 1'b0;
`ifdef ACPRAM_ARB_PRIO0_EN
      last0_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      len_q    <= len_d;
      aa_q     <= aa_d;
      xa_q     <= xa_d;
      err_q    <= err_d;
`ifdef ACPRAM_ARB_PRIO0_EN
      last0_q  <= last0_d;
`endif
    end
  end

  assign eng_len_o         = len_q;
  assign eng_acpram_addr_o = aa_q;
  assign eng_axi_addr_o    = xa_q;
  assign grant_id_o        = grant_q;
  assign active_o          = (state_q != S_IDLE);

  // An engine completion is only expected while a job is waiting on it.
  a_done_when_waiting: assert property (@(posedge clock_i) disable iff (!resetn_i)
    eng_done_i |-> (state_q != S_IDLE && state_q != S_ISSUE));

endmodule
